// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Purpose:
//   Shares one external, single-cycle-latency ALU between two requesters.
//   Each requester may have at most one operation in flight plus one
//   buffered result.  Conflicts are resolved round-robin by default.
//   Results are steered back to the issuing requester using a
//   one-cycle in-flight tag.
//
// Configuration:
//   ALU_ARB_FIXED_PRIO_EN  When defined, requester 0 wins every conflict
//                          and the round-robin pointer is removed.
//
// Parameters:
//   XLEN          operand/result width (only 32 is supported)
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   reqN_valid    requester N presents an operation (N = 0,1)
//   reqN_ready    requester N's operation is accepted this cycle
//   reqN_funct3   requester N operation select
//   reqN_funct7   requester N operation modifier
//   reqN_opd1/2   requester N operands
//   rspN_valid    result for requester N is held in its response slot
//   rspN_ready    requester N consumes its result this cycle
//   rspN_rslt     result for requester N
//   alu_funct3/7  fields driven to the shared ALU
//   alu_opd1/2    operands driven to the shared ALU
//   alu_rslt      ALU result, valid one cycle after its operands
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_funct3,
  input  logic [6:0]      req0_funct7,
  input  logic [XLEN-1:0] req0_opd1,
  input  logic [XLEN-1:0] req0_opd2,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_rslt,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_funct3,
  input  logic [6:0]      req1_funct7,
  input  logic [XLEN-1:0] req1_opd1,
  input  logic [XLEN-1:0] req1_opd2,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_rslt,

  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_opd1,
  output logic [XLEN-1:0] alu_opd2,
  input  logic [XLEN-1:0] alu_rslt
);

  logic inflight0;
  logic inflight1;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer: names the requester that wins the next conflict.
  logic prio;
`endif

  // A requester is eligible only when nothing of its own is in flight and
  // its response slot is free or being emptied this cycle, so a result
  // arriving next cycle always has somewhere to land.  Reset masks all
  // eligibility so no request is accepted while rst is high.
  always_comb begin
    elig0 = req0_valid && !inflight0 && (!rsp0_valid || rsp0_ready) && !rst;
    elig1 = req1_valid && !inflight1 && (!rsp1_valid || rsp1_ready) && !rst;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant0 = elig0;
    grant1 = elig1 && !elig0;
`else
    grant0 = elig0 && (!elig1 || !prio);
    grant1 = elig1 && (!elig0 || prio);
`endif
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Requester 0's fields are the default path to the ALU; its result is
  // simply dropped when no in-flight tag is set the following cycle.
  always_comb begin
    if (grant1) begin
      alu_funct3 = req1_funct3;
      alu_funct7 = req1_funct7;
      alu_opd1   = req1_opd1;
      alu_opd2   = req1_opd2;
    end else begin
      alu_funct3 = req0_funct3;
      alu_funct7 = req0_funct7;
      alu_opd1   = req0_opd1;
      alu_opd2   = req0_opd2;
    end
  end

  // In-flight tags last exactly one cycle, matching the ALU latency.  A
  // capture takes precedence over a consume on the same edge so the slot
  // stays valid with the fresh result.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight0  <= 1'b0;
      inflight1  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rslt  <= '0;
      rsp1_rslt  <= '0;
    end else begin
      inflight0 <= grant0;
      inflight1 <= grant1;

      if (inflight0) begin
        rsp0_rslt  <= alu_rslt;
        rsp0_valid <= 1'b1;
      end else if (rsp0_valid && rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end

      if (inflight1) begin
        rsp1_rslt  <= alu_rslt;
        rsp1_valid <= 1'b1;
      end else if (rsp1_valid && rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // After a grant the other requester gets priority; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (grant0) begin
      prio <= 1'b1;
    end else if (grant1) begin
      prio <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//
// Purpose:
//   Self-checking bench for alu_arbiter.  A behavioural one-cycle ALU sits
//   on the alu_* port.  A table of per-cycle vectors drives both
//   requesters and lists hand-computed ready/valid/result values, followed
//   by two short hand-written sequences.
//
// Configuration:
//   ALU_ARB_FIXED_PRIO_EN  selects the fixed-priority expected grants.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [6:0]  req0_funct7, req1_funct7;
  logic [31:0] req0_opd1, req0_opd2, req1_opd1, req1_opd2;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_rslt, rsp1_rslt;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_opd1, alu_opd2;
  logic [31:0] alu_rslt;

  int checks;
  int errors;

  typedef struct {
    string       name;
    logic        rst;
    logic        v0;
    logic [2:0]  f3_0;
    logic [6:0]  f7_0;
    logic [31:0] a0, b0;
    logic        rr0;
    logic        v1;
    logic [2:0]  f3_1;
    logic [6:0]  f7_1;
    logic [31:0] a1, b1;
    logic        rr1;
    logic        e_rdy0, e_rdy1, e_rv0;
    logic [31:0] e_r0;
    logic        e_rv1;
    logic [31:0] e_r1;
  } vec_t;

  vec_t vecs[$];

  alu_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req0_opd1(req0_opd1), .req0_opd2(req0_opd2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rslt(rsp0_rslt),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .req1_opd1(req1_opd1), .req1_opd2(req1_opd2),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rslt(rsp1_rslt),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_rslt(alu_rslt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RV32 integer ALU with one cycle of latency.
  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = f7[5] ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'b0, ($signed(a) < $signed(b))};
      3'd3:    r = {31'b0, (a < b)};
      3'd4:    r = a ^ b;
      3'd5:    r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always @(posedge clk) alu_rslt <= alu_model(alu_funct3, alu_funct7, alu_opd1, alu_opd2);

  task automatic addRow(input string name, input logic r,
                        input logic v0, input logic [2:0] f30, input logic [6:0] f70,
                        input logic [31:0] a0, input logic [31:0] b0, input logic rr0,
                        input logic v1, input logic [2:0] f31, input logic [6:0] f71,
                        input logic [31:0] a1, input logic [31:0] b1, input logic rr1,
                        input logic erdy0, input logic erdy1, input logic erv0,
                        input logic [31:0] er0, input logic erv1, input logic [31:0] er1);
    vec_t v;
    v.name = name; v.rst = r;
    v.v0 = v0; v.f3_0 = f30; v.f7_0 = f70; v.a0 = a0; v.b0 = b0; v.rr0 = rr0;
    v.v1 = v1; v.f3_1 = f31; v.f7_1 = f71; v.a1 = a1; v.b1 = b1; v.rr1 = rr1;
    v.e_rdy0 = erdy0; v.e_rdy1 = erdy1; v.e_rv0 = erv0; v.e_r0 = er0;
    v.e_rv1 = erv1; v.e_r1 = er1;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    req0_valid  = v.v0;
    req0_funct3 = v.f3_0;
    req0_funct7 = v.f7_0;
    req0_opd1   = v.a0;
    req0_opd2   = v.b0;
    rsp0_ready  = v.rr0;
    req1_valid  = v.v1;
    req1_funct3 = v.f3_1;
    req1_funct7 = v.f7_1;
    req1_opd1   = v.a1;
    req1_opd2   = v.b1;
    rsp1_ready  = v.rr1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t idle;
    int   lat;
    bit   got;

    checks = 0;
    errors = 0;
    idle = '{name: "idle", rst: 1'b0, v0: 1'b0, f3_0: 3'd0, f7_0: 7'd0, a0: 32'd0, b0: 32'd0,
             rr0: 1'b1, v1: 1'b0, f3_1: 3'd0, f7_1: 7'd0, a1: 32'd0, b1: 32'd0, rr1: 1'b1,
             e_rdy0: 1'b0, e_rdy1: 1'b0, e_rv0: 1'b0, e_r0: 32'd0, e_rv1: 1'b0, e_r1: 32'd0};
    applyStimulus(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    //      name        rst v0 f3 f7    a   b  rr0 v1 f3 f7   a   b  rr1 rdy0 rdy1 rv0 r0 rv1 r1
    addRow("reset",     1, 1, 0, 0,     5,  7, 1,  1, 0, 0,   1,  1, 1,  0, 0, 0, 0,  0, 0);
    addRow("add_acc",   0, 1, 0, 0,     5,  7, 1,  0, 0, 0,   0,  0, 1,  1, 0, 0, 0,  0, 0);
    addRow("add_fly",   0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 0,  0, 0);
    addRow("add_rsp",   0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 1, 12, 0, 0);
    addRow("add_clr",   0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 12, 0, 0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    addRow("both_c0",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  1, 0, 0, 12, 0, 0);
    addRow("both_c1",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  0, 1, 0, 12, 0, 0);
    addRow("both_c2",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  1, 0, 1, 7,  0, 0);
    addRow("both_c3",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  0, 1, 0, 7,  1, 1);
    addRow("both_c4",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  1, 0, 1, 7,  0, 1);
    addRow("drain_c0",  0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 7,  1, 1);
    addRow("drain_c1",  0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 1, 7,  0, 1);
`else
    addRow("both_c0",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  0, 1, 0, 12, 0, 0);
    addRow("both_c1",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  1, 0, 0, 12, 0, 0);
    addRow("both_c2",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  0, 1, 0, 12, 1, 1);
    addRow("both_c3",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  1, 0, 1, 7,  0, 1);
    addRow("both_c4",   0, 1, 0, 7'h20, 10, 3, 1,  1, 3, 0,   3, 10, 1,  0, 1, 0, 7,  1, 1);
    addRow("drain_c0",  0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 1, 7,  0, 1);
    addRow("drain_c1",  0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 7,  1, 1);
`endif
    addRow("drain_c2",  0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 7,  0, 1);
    addRow("bp_acc",    0, 1, 0, 0,     1,  2, 0,  0, 0, 0,   0,  0, 1,  1, 0, 0, 7,  0, 1);
    addRow("bp_fly",    0, 0, 0, 0,     0,  0, 0,  0, 0, 0,   0,  0, 1,  0, 0, 0, 7,  0, 1);
    addRow("bp_hold0",  0, 1, 0, 0,     4,  4, 0,  0, 0, 0,   0,  0, 1,  0, 0, 1, 3,  0, 1);
    addRow("bp_hold1",  0, 1, 0, 0,     4,  4, 0,  0, 0, 0,   0,  0, 1,  0, 0, 1, 3,  0, 1);
    addRow("bp_release",0, 1, 0, 0,     4,  4, 1,  0, 0, 0,   0,  0, 1,  1, 0, 1, 3,  0, 1);
    addRow("bp_fly2",   0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 3,  0, 1);
    addRow("bp_rsp",    0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 1, 8,  0, 1);
    addRow("bp_clr",    0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 8,  0, 1);
    addRow("rst_acc",   0, 1, 0, 0,     9,  9, 1,  0, 0, 0,   0,  0, 1,  1, 0, 0, 8,  0, 1);
    addRow("rst_hit",   1, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 8,  0, 1);
    addRow("rst_after0",0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 0,  0, 0);
    addRow("rst_after1",0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 0,  0, 0);
    addRow("post_both", 0, 1, 0, 0,     2,  3, 1,  1, 4, 0,   6,  3, 1,  1, 0, 0, 0,  0, 0);
    addRow("post_r1",   0, 0, 0, 0,     0,  0, 1,  1, 4, 0,   6,  3, 1,  0, 1, 0, 0,  0, 0);
    addRow("post_rsp0", 0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 1, 5,  0, 0);
    addRow("post_rsp1", 0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 5,  1, 5);
    addRow("post_idle", 0, 0, 0, 0,     0,  0, 1,  0, 0, 0,   0,  0, 1,  0, 0, 0, 5,  0, 5);

    // Table: drive at the falling edge, check 1 time unit later.
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, ".req0_ready"}, 32'(req0_ready), 32'(vecs[i].e_rdy0));
      checkOutput({vecs[i].name, ".req1_ready"}, 32'(req1_ready), 32'(vecs[i].e_rdy1));
      checkOutput({vecs[i].name, ".rsp0_valid"}, 32'(rsp0_valid), 32'(vecs[i].e_rv0));
      checkOutput({vecs[i].name, ".rsp0_rslt"},  rsp0_rslt,        vecs[i].e_r0);
      checkOutput({vecs[i].name, ".rsp1_valid"}, 32'(rsp1_valid), 32'(vecs[i].e_rv1));
      checkOutput({vecs[i].name, ".rsp1_rslt"},  rsp1_rslt,        vecs[i].e_r1);
    end

    // Sequence A: ALU results with no in-flight tag must be discarded.
    @(negedge clk);
    applyStimulus(idle);
    req0_funct3 = 3'd0;
    req0_opd1   = 32'd100;
    req0_opd2   = 32'd1;
    req1_opd1   = 32'd200;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("seqA.rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("seqA.rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("seqA.rsp0_rslt",  rsp0_rslt,        32'd5);
    checkOutput("seqA.rsp1_rslt",  rsp1_rslt,        32'd5);

    // Sequence B: lone req1 ADD 20+22, bounded wait for its response.
    @(negedge clk);
    req1_valid  = 1'b1;
    req1_funct3 = 3'd0;
    req1_funct7 = 7'd0;
    req1_opd1   = 32'd20;
    req1_opd2   = 32'd22;
    #1;
    checkOutput("seqB.req1_ready", 32'(req1_ready), 32'd1);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6 && !got; i++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      if (rsp1_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    checkOutput("seqB.timeout",  32'(got), 32'd1);
    checkOutput("seqB.latency",  32'(lat), 32'd2);
    checkOutput("seqB.rsp1_rslt", rsp1_rslt, 32'd42);
    checkOutput("seqB.rsp0_valid", 32'(rsp0_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an ALU operation.
REQ-005 reqN_ready  output  1  operation of requester N accepted this cycle when high with reqN_valid.
REQ-006 reqN_funct3  input  3  requester N operation select.
REQ-007 reqN_funct7  input  7  requester N operation modifier (bit 5 significant).
REQ-008 reqN_opd1, reqN_opd2  input  XLEN  requester N operands.
REQ-009 rspN_valid  output  1  result for requester N held in its response slot.
REQ-010 rspN_ready  input  1  requester N consumes its result this cycle.
REQ-011 rspN_rslt  output  XLEN  result for requester N, stable while rspN_valid and not consumed.
REQ-012 alu_funct3, alu_funct7, alu_opd1, alu_opd2  output  3/7/XLEN/XLEN  fields driven to the shared ALU.
REQ-013 alu_rslt  input  XLEN  ALU result, valid exactly one cycle after its operands are driven.

Function
REQ-014 Requester N SHALL be eligible iff reqN_valid and inflightN==0 and (rspN_valid==0 or rspN_ready==1).
REQ-015 At most one request SHALL be accepted per cycle; reqN_ready SHALL be high only for the granted requester and only when it is eligible.
REQ-016 With one eligible requester, that requester SHALL be granted; with both eligible, the requester named by the priority pointer prio SHALL be granted.
REQ-017 After any grant to requester N, prio SHALL become 1-N; with no grant, prio SHALL hold.
REQ-018 alu_* outputs SHALL combinationally carry the granted requester's fields; with no grant they SHALL carry requester 0's fields (ALU result ignored).
REQ-019 Acceptance in cycle T SHALL set inflightN for cycle T+1 only; alu_rslt in T+1 SHALL be written to rspN_rslt at the end of T+1, rspN_valid high from T+2.
REQ-020 rspN_valid SHALL clear at the edge where rspN_valid and rspN_ready are both high, unless a capture for N occurs on the same edge, in which case it SHALL remain high with the new result.
REQ-021 Ungranted in-flight cycles SHALL not alter any response slot; ALU results not associated with an in-flight tag SHALL be discarded.
REQ-022 Per requester: at most one operation in flight plus one buffered result; with rspN_ready tied high, one acceptance every 2 cycles per requester, and alternating requesters SHALL sustain one ALU issue per cycle.
REQ-023 Results SHALL be returned to each requester in its acceptance order and never to the other requester.
REQ-024 reqN_ready SHALL not depend combinationally on reqN_valid of the same requester except through the grant decision.

Reset
REQ-025 rst high at a clock edge SHALL clear rsp0_valid, rsp1_valid, inflight0, inflight1 and set prio=0; rspN_rslt SHALL reset to 0.
REQ-026 rst asserted while an operation is in flight SHALL discard it; no rspN_valid SHALL appear for it after reset.
REQ-027 While rst is high, reqN_ready SHALL be 0.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL win every conflict and prio SHALL be unused (held 0).
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-016/REQ-017 SHALL apply.

Verification
REQ-030 After reset, req0 ADD opd1=5 opd2=7, rsp0_ready=1 -> req0_ready=1 in T, rsp0_valid=1 rsp0_rslt=12 in T+2 only.
REQ-031 Both requesters valid every cycle, rspN_ready=1 -> grants alternate 0,1,0,1; each rspN_rslt matches its own operands (req0 SUB 10-3=7, req1 SLTU 3<10=1).
REQ-032 Fixed-prio build, same stimulus -> req0 granted cycles T, T+2, T+4; req1 granted T+1, T+3 (only when req0 ineligible).
REQ-033 rsp0_ready=0 with rsp0_valid=1 -> req0_ready stays 0 and rsp0_rslt stable; raise rsp0_ready -> req0 accepted that same cycle, new result at T+2.
REQ-034 Assert rst in cycle T+1 after acceptance at T -> no rsp0_valid in T+2 or later; prio=0; next request accepted normally.
